// File: rtl/sy_ppl_ras_if.sv
// Shared types for the fetch-stage quick decoder and the bundle of signals
// between the quick decoder/fetch unit and the return address stack.
package sy_pkg;
    localparam int AWTH = 32;

    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        BRANCH    = 3'd1,
        JUMP      = 3'd2,
        JALR      = 3'd3,
        CALL_JAL  = 3'd4,
        CALL_JALR = 3'd5,
        RET       = 3'd6
    } qdec_type_e;
endpackage

interface sy_ppl_ras_if #(
    parameter int DEPTH = 8,
    parameter int CWTH  = $clog2(DEPTH + 1)
) ();
    logic                     flush_i;
    logic                     valid_i;
    sy_pkg::qdec_type_e       instr_type_i;
    logic                     instr_is_c_i;
    logic [sy_pkg::AWTH-1:0]  vaddr_i;
    logic                     ras_valid_o;
    logic [sy_pkg::AWTH-1:0]  ras_addr_o;
    logic [CWTH-1:0]          count_o;

    // Fetch/decode side: drives the classified instruction, consumes the prediction.
    modport master (
        output flush_i, valid_i, instr_type_i, instr_is_c_i, vaddr_i,
        input  ras_valid_o, ras_addr_o, count_o
    );

    // Stack side.
    modport slave (
        input  flush_i, valid_i, instr_type_i, instr_is_c_i, vaddr_i,
        output ras_valid_o, ras_addr_o, count_o
    );
endinterface

// File: rtl/sy_ppl_ras.sv
// Speculative return address stack. Calls push their return address, returns
// pop; the top entry is the predicted RET target. Storage is circular so an
// overflowing push silently replaces the oldest entry. Flush empties the stack
// without touching entry contents.
module sy_ppl_ras
    import sy_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CWTH  = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    sy_ppl_ras_if.slave   ras
);
    localparam int PWTH = $clog2(DEPTH);
    localparam logic [CWTH-1:0] FULL = CWTH'(DEPTH);

    logic [AWTH-1:0] entry [DEPTH];
    logic [PWTH-1:0] tos;
    logic [CWTH-1:0] cnt;

    logic            push;
    logic            pop;
    logic [PWTH-1:0] tos_inc;
    logic [PWTH-1:0] tos_dec;
    logic [AWTH-1:0] ret_addr;

    // Decode the stack operation; the type encoding keeps push and pop exclusive.
    always_comb begin
        push     = ras.valid_i && (ras.instr_type_i == CALL_JAL ||
                                   ras.instr_type_i == CALL_JALR);
        pop      = ras.valid_i && (ras.instr_type_i == RET) && (cnt != '0);
        tos_inc  = tos + PWTH'(1);
        tos_dec  = tos - PWTH'(1);
        ret_addr = ras.vaddr_i + (ras.instr_is_c_i ? AWTH'(2) : AWTH'(4));
    end

    // Pointer and occupancy; flush wins over any concurrent push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tos <= '0;
            cnt <= '0;
        end else if (ras.flush_i) begin
            tos <= '0;
            cnt <= '0;
        end else if (push) begin
            tos <= tos_inc;
            if (cnt != FULL) begin
                cnt <= cnt + CWTH'(1);
            end
        end else if (pop) begin
            tos <= tos_dec;
            cnt <= cnt - CWTH'(1);
        end
    end

    // One register per slot; a push writes the slot just above the current top,
    // which on overflow is the oldest live entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Slot gi captures the return address when it becomes the new top.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                entry[gi] <= '0;
            end else if (!ras.flush_i && push && tos_inc == PWTH'(gi)) begin
                entry[gi] <= ret_addr;
            end
        end
    end

    // Outputs come from registers only; no same-cycle bypass of a push.
    always_comb begin
        ras.ras_addr_o  = entry[tos];
        ras.ras_valid_o = (cnt != '0);
        ras.count_o     = cnt;
    end
endmodule

// File: tb/tb_sy_ppl_ras.sv
// Bench for sy_ppl_ras: directed scenarios plus a randomized run, all checked
// against a queue-of-return-addresses model of the stack.
module tb_sy_ppl_ras;
    import sy_pkg::*;

    localparam int DEPTH = 8;
    localparam int CWTH  = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    sy_ppl_ras_if #(.DEPTH(DEPTH)) bus ();

    sy_ppl_ras #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ras   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: live return addresses, newest at the back.
    logic [AWTH-1:0] model_q [$];

    function automatic void model_update(input logic flush, input logic valid,
                                         input qdec_type_e t, input logic is_c,
                                         input logic [AWTH-1:0] va);
        logic [AWTH-1:0] ra;
        if (flush) begin
            model_q.delete();
        end else if (valid) begin
            if (t == CALL_JAL || t == CALL_JALR) begin
                ra = va + (is_c ? 32'd2 : 32'd4);
                model_q.push_back(ra);
                if (model_q.size() > DEPTH) void'(model_q.pop_front());
            end else if (t == RET && model_q.size() > 0) begin
                void'(model_q.pop_back());
            end
        end
    endfunction

    // Apply one instruction for one clock, then settle past the edge.
    task automatic drive(input logic flush, input logic valid, input qdec_type_e t,
                         input logic is_c, input logic [AWTH-1:0] va);
        bus.flush_i      = flush;
        bus.valid_i      = valid;
        bus.instr_type_i = t;
        bus.instr_is_c_i = is_c;
        bus.vaddr_i      = va;
        @(posedge clk);
        #1;
        model_update(flush, valid, t, is_c, va);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (bus.count_o !== '0 || bus.ras_valid_o !== 1'b0 || bus.ras_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset: count=%0d valid=%0b addr=%h, required 0/0/0",
                     bus.count_o, bus.ras_valid_o, bus.ras_addr_o);
        end
    endtask

    task automatic test_idle;
        qdec_type_e kinds [3] = '{NORMAL, BRANCH, JALR};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, kinds[i], 1'b0, 32'h0000_4000 + 32'(i * 4));
            n_checks++;
            if (bus.count_o !== '0 || bus.ras_valid_o !== 1'b0 || bus.ras_addr_o !== '0) begin
                n_fail++;
                $display("FAIL idle_%s: count=%0d valid=%0b addr=%h, required 0/0/0",
                         kinds[i].name(), bus.count_o, bus.ras_valid_o, bus.ras_addr_o);
            end
        end
    endtask

    task automatic test_mixed;
        drive(1'b0, 1'b1, CALL_JAL, 1'b0, 32'h1000);
        n_checks++;
        if (bus.ras_addr_o !== 32'h1004 || bus.count_o !== CWTH'(1)) begin
            n_fail++;
            $display("FAIL mixed_call_jal: addr=%h count=%0d, required 1004/1",
                     bus.ras_addr_o, bus.count_o);
        end
        drive(1'b0, 1'b1, CALL_JALR, 1'b1, 32'h2002);
        n_checks++;
        if (bus.ras_addr_o !== 32'h2004 || bus.count_o !== CWTH'(2)) begin
            n_fail++;
            $display("FAIL mixed_call_jalr_c: addr=%h count=%0d, required 2004/2",
                     bus.ras_addr_o, bus.count_o);
        end
        drive(1'b0, 1'b1, RET, 1'b0, 32'h3000);
        n_checks++;
        if (bus.ras_addr_o !== 32'h1004 || bus.count_o !== CWTH'(1)) begin
            n_fail++;
            $display("FAIL mixed_ret1: addr=%h count=%0d, required 1004/1",
                     bus.ras_addr_o, bus.count_o);
        end
        drive(1'b0, 1'b1, RET, 1'b0, 32'h3004);
        n_checks++;
        if (bus.ras_valid_o !== 1'b0 || bus.count_o !== '0) begin
            n_fail++;
            $display("FAIL mixed_ret2: valid=%0b count=%0d, required 0/0",
                     bus.ras_valid_o, bus.count_o);
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) drive(1'b0, 1'b1, CALL_JAL, 1'b0, 32'(i * 256));
        n_checks++;
        if (bus.count_o !== CWTH'(8) || bus.ras_addr_o !== 32'h904) begin
            n_fail++;
            $display("FAIL overflow_fill: count=%0d addr=%h, required 8/904",
                     bus.count_o, bus.ras_addr_o);
        end
        for (int i = 9; i >= 2; i--) begin
            n_checks++;
            if (bus.ras_valid_o !== 1'b1 || bus.ras_addr_o !== 32'(i * 256 + 4)) begin
                n_fail++;
                $display("FAIL overflow_ret_%0d: valid=%0b addr=%h, required 1/%h",
                         i, bus.ras_valid_o, bus.ras_addr_o, 32'(i * 256 + 4));
            end
            drive(1'b0, 1'b1, RET, 1'b0, 32'h0);
        end
        n_checks++;
        if (bus.ras_valid_o !== 1'b0 || bus.count_o !== '0) begin
            n_fail++;
            $display("FAIL overflow_empty: valid=%0b count=%0d, required 0/0",
                     bus.ras_valid_o, bus.count_o);
        end
        drive(1'b0, 1'b1, RET, 1'b0, 32'h0);
        n_checks++;
        if (bus.ras_valid_o !== 1'b0 || bus.count_o !== '0) begin
            n_fail++;
            $display("FAIL overflow_ret9: valid=%0b count=%0d, required 0/0",
                     bus.ras_valid_o, bus.count_o);
        end
    endtask

    task automatic test_underflow;
        drive(1'b0, 1'b1, RET, 1'b0, 32'h0);
        n_checks++;
        if (bus.count_o !== '0 || bus.ras_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_ret: count=%0d valid=%0b, required 0/0",
                     bus.count_o, bus.ras_valid_o);
        end
        drive(1'b0, 1'b1, CALL_JALR, 1'b1, 32'h5550);
        n_checks++;
        if (bus.count_o !== CWTH'(1) || bus.ras_addr_o !== 32'h5552) begin
            n_fail++;
            $display("FAIL underflow_push: count=%0d addr=%h, required 1/5552",
                     bus.count_o, bus.ras_addr_o);
        end
        drive(1'b0, 1'b1, RET, 1'b0, 32'h0);
        n_checks++;
        if (bus.count_o !== '0 || bus.ras_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_pop: count=%0d valid=%0b, required 0/0",
                     bus.count_o, bus.ras_valid_o);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, CALL_JAL, 1'b0, 32'h700 + 32'(i * 16));
        n_checks++;
        if (bus.count_o !== CWTH'(3)) begin
            n_fail++;
            $display("FAIL flush_setup: count=%0d, required 3", bus.count_o);
        end
        drive(1'b1, 1'b1, CALL_JAL, 1'b0, 32'h800);
        n_checks++;
        if (bus.count_o !== '0 || bus.ras_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_prio: count=%0d valid=%0b, required 0/0",
                     bus.count_o, bus.ras_valid_o);
        end
        drive(1'b0, 1'b1, CALL_JAL, 1'b0, 32'h3000);
        n_checks++;
        if (bus.ras_addr_o !== 32'h3004 || bus.count_o !== CWTH'(1)) begin
            n_fail++;
            $display("FAIL flush_push: addr=%h count=%0d, required 3004/1",
                     bus.ras_addr_o, bus.count_o);
        end
    endtask

    // Back-to-back random traffic with occasional flushes; a valid RET also
    // checks that the pre-pop top is the model's prediction.
    task automatic test_random;
        qdec_type_e      t;
        logic            v, c, f;
        logic [AWTH-1:0] va;
        for (int i = 0; i < 400; i++) begin
            t  = qdec_type_e'($urandom_range(0, 6));
            v  = ($urandom_range(0, 9) != 0);
            c  = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 39) == 0);
            va = (i % 50 == 7) ? 32'hFFFF_FFFE : ($urandom & 32'hFFFF_FFFE);
            if (v && !f && t == RET && model_q.size() > 0) begin
                n_checks++;
                if (bus.ras_addr_o !== model_q[$]) begin
                    n_fail++;
                    $display("FAIL rand_predict[%0d]: addr=%h, required %h",
                             i, bus.ras_addr_o, model_q[$]);
                end
            end
            drive(f, v, t, c, va);
            n_checks++;
            if (bus.count_o !== CWTH'(model_q.size()) ||
                bus.ras_valid_o !== (model_q.size() != 0) ||
                (model_q.size() != 0 && bus.ras_addr_o !== model_q[$])) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: count=%0d valid=%0b addr=%h, required %0d/%0b/%h",
                         i, bus.count_o, bus.ras_valid_o, bus.ras_addr_o, model_q.size(),
                         model_q.size() != 0, (model_q.size() != 0) ? model_q[$] : 32'h0);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 1'b0, NORMAL, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, CALL_JAL, 1'b0, 32'hA000 + 32'(i * 8));
        n_checks++;
        if (bus.count_o !== CWTH'(4)) begin
            n_fail++;
            $display("FAIL async_setup: count=%0d, required 4", bus.count_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.count_o !== '0 || bus.ras_valid_o !== 1'b0 || bus.ras_addr_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d valid=%0b addr=%h, required 0/0/0",
                     bus.count_o, bus.ras_valid_o, bus.ras_addr_o);
        end
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.flush_i      = 1'b0;
        bus.valid_i      = 1'b0;
        bus.instr_type_i = NORMAL;
        bus.instr_is_c_i = 1'b0;
        bus.vaddr_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_mixed();
        test_overflow();
        test_underflow();
        test_flush();
        test_random();
        test_async_reset();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sy_ppl_ras.md
# sy_ppl_ras

Speculative return address stack for the fetch stage. It consumes the per-instruction quick-decode classification (`qdec_type_e`, compressed flag, instruction vaddr) and sits directly downstream of the quick decoder. It pushes the return address of every call and pops on every return. The top-of-stack entry is the predicted target the fetch unit uses for `RET`. A backend flush discards all speculative contents.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, >= 2.
- `CWTH`, `$clog2(DEPTH+1)`, width of the occupancy count.

Ports (`AWTH` and `qdec_type_e` come from `sy_pkg`):
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `flush_i` input 1: pipeline flush; empties the stack.
- `valid_i` input 1: the decoded instruction is accepted by fetch this cycle. Without it there is no stack update.
- `instr_type_i` input `qdec_type_e`: quick-decode class (NORMAL, BRANCH, JUMP, JALR, CALL_JAL, CALL_JALR, RET).
- `instr_is_c_i` input 1: instruction is 16-bit compressed.
- `vaddr_i` input AWTH: virtual address of the instruction.
- `ras_valid_o` output 1: stack is non-empty; `ras_addr_o` is meaningful.
- `ras_addr_o` output AWTH: current top-of-stack return address.
- `count_o` output CWTH: number of valid entries, 0..DEPTH.

## Operation
- State:
  - `entry[DEPTH]` (AWTH each).
  - `tos` pointer, log2(DEPTH) bits, index of the top entry.
  - `cnt`, CWTH bits.
- Return address for a push: `vaddr_i + (instr_is_c_i ? 2 : 4)`, computed modulo 2^AWTH. Wrap-around of the address is silent.
- Push on `valid_i & (instr_type_i == CALL_JAL | instr_type_i == CALL_JALR)`:
  - `tos <= tos + 1` (mod DEPTH).
  - `entry[tos+1] <= return address`.
  - `cnt <= min(cnt + 1, DEPTH)`.
- Overflow: a push while `cnt == DEPTH` overwrites the oldest entry (circular). `cnt` stays at DEPTH.
- Pop on `valid_i & instr_type_i == RET & cnt != 0`:
  - `tos <= tos - 1` (mod DEPTH).
  - `cnt <= cnt - 1`.
  - Entry contents are not cleared.
- Pop while empty (`cnt == 0`): no state change.
- NORMAL, BRANCH, JUMP and JALR never modify state.
- At most one push or pop per cycle. The `qdec_type_e` encoding makes push and pop mutually exclusive.
- `flush_i` has priority over `valid_i`:
  - `cnt <= 0`, `tos <= 0`.
  - Entries are left as they are.
  - Any concurrent push or pop is dropped.
- Outputs:
  - `ras_addr_o = entry[tos]`.
  - `ras_valid_o = (cnt != 0)`.
  - `count_o = cnt`.
  - All three are combinational from registers only; there is no input-to-output path.

## Timing
- Reset values: every entry 0, `tos` 0, `cnt` 0. Therefore `ras_valid_o = 0`, `ras_addr_o = 0`, `count_o = 0`.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of clock.
- A push in cycle N is visible on `ras_addr_o`/`ras_valid_o` in cycle N+1. There is no same-cycle bypass.
- A `RET` in cycle N uses the `ras_addr_o` value present in cycle N (pre-pop) as its prediction. The pop takes effect in cycle N+1.
- CALL in cycle N followed by RET in cycle N+1: the RET sees the address pushed in cycle N.
- Flush in cycle N: `ras_valid_o = 0` and `count_o = 0` from cycle N+1.
- Consecutive pushes or pops every cycle are supported without stalls. There is no backpressure output.

## Test plan
- Reset then idle:
  - Check all outputs are 0.
  - Send `valid_i=1` with NORMAL, BRANCH and JALR: outputs are unchanged.
- Mixed push widths and ordering:
  - CALL_JAL at vaddr 0x1000 (`is_c=0`): next cycle `ras_addr_o=0x1004`, `count_o=1`.
  - CALL_JALR at 0x2002 (`is_c=1`): `ras_addr_o=0x2004`, `count_o=2`.
  - RET: `ras_addr_o=0x1004`, `count_o=1`.
  - RET: `ras_valid_o=0`.
- Overflow (DEPTH=8):
  - Push 9 calls at 0x100, 0x200, ..., 0x900 (`is_c=0`): `count_o=8`, top is 0x904.
  - 8 RETs show 0x904 down to 0x204.
  - The 9th RET sees `ras_valid_o=0` and no state change.
- Underflow: RET with `valid_i=1` on an empty stack keeps `count_o=0`. A following push then pops correctly.
- Flush priority:
  - With 3 entries, assert `flush_i` together with a CALL: next cycle `count_o=0`, `ras_valid_o=0`.
  - A new CALL at 0x3000 then yields `ras_addr_o=0x3004`, `count_o=1`.
- Async reset mid-stream: assert `rst_i` between clock edges while `count_o=4`. Outputs go to 0 before the next edge.
